shift_unit: RTL and testbench

Parametrised, multi-cycle registered shifter for the MIPS execute stage, replacing the fixed shift-by-constant register. It accepts a data word, a variable shift amount and an operation (logical left, logical right, arithmetic right, rotate left). It applies at most `STEP` bit positions per cycle and presents a registered result with a one-cycle `done` pulse. The hazard unit uses `busy` and `flush` to stall the pipeline and to squash an in-flight shift.

---
 rtl/shift_pkg.sv | 15 +
 rtl/shift_step.sv | 36 +++
 rtl/shift_unit.sv | 117 +++++++++++
 tb/tb_shift_unit.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the execute-stage multi-cycle shifter.
package shift_pkg;

   localparam logic [1:0] SH_SLL  = 2'b00;
   localparam logic [1:0] SH_SRL  = 2'b01;
   localparam logic [1:0] SH_SRA  = 2'b10;
   localparam logic [1:0] SH_ROTL = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

endpackage

// File: rtl/shift_step.sv
// One bounded shift step: a log2(STEP)+1 stage mux barrel moving acc by amt (0..STEP).
module shift_step
   import shift_pkg::*;
#(
   parameter int unsigned N    = 32,
   parameter int unsigned STEP = 8,
   localparam int unsigned AW  = $clog2(STEP) + 1
) (
   input  logic [N-1:0]  acc,
   input  logic [1:0]    op,
   input  logic          sign,
   input  logic [AW-1:0] amt,
   output logic [N-1:0]  shifted
);

   // Fixed-distance shift for one barrel stage; d never exceeds N.
   function automatic logic [N-1:0] stage(input logic [N-1:0] x, input logic [1:0] o,
                                          input logic s, input int unsigned d);
      logic [N-1:0] fill;
      fill = s ? ~({N{1'b1}} >> d) : '0;
      case (o)
         SH_SLL:  stage = x << d;
         SH_SRL:  stage = x >> d;
         SH_SRA:  stage = (x >> d) | fill;
         default: stage = (x << d) | (x >> (N - d));
      endcase
   endfunction

   always_comb begin
      shifted = acc;
      for (int k = 0; k < int'(AW); k++) begin
         if (amt[k]) shifted = stage(shifted, op, sign, 32'd1 << k);
      end
   end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle registered shifter (SLL/SRL/SRA/ROTL), at most STEP positions per cycle.
module shift_unit
   import shift_pkg::*;
#(
   parameter int unsigned N    = 32,
   parameter int unsigned STEP = 8,
   parameter int unsigned SHW  = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           flush,
   input  logic           start_valid,
   output logic           start_ready,
   input  logic [1:0]     op,
   input  logic [N-1:0]   din,
   input  logic [SHW-1:0] shamt,
   output logic [N-1:0]   result,
   output logic           done,
   output logic           busy
);

   localparam int unsigned AW = $clog2(STEP) + 1;

   state_t         state, state_d;
   logic [N-1:0]   acc, acc_d, result_d, shifted;
   logic [SHW-1:0] rem, rem_d, rem_next;
   logic [1:0]     op_q, op_d;
   logic           sign, sign_d;
   logic [AW-1:0]  amt;

   assign start_ready = (state == ST_IDLE) && !flush && !rst;

   // This cycle's step is min(rem, STEP).
   always_comb begin
      if (32'(rem) >= STEP) amt = AW'(STEP);
      else                  amt = AW'(rem);
      rem_next = rem - SHW'(amt);
   end

   shift_step #(.N(N), .STEP(STEP)) u_step (
      .acc     (acc),
      .op      (op_q),
      .sign    (sign),
      .amt     (amt),
      .shifted (shifted)
   );

   always_comb begin
      state_d  = state;
      acc_d    = acc;
      rem_d    = rem;
      op_d     = op_q;
      sign_d   = sign;
      result_d = result;
      case (state)
         ST_IDLE: begin
            if (start_valid && start_ready) begin
               op_d   = op;
               acc_d  = din;
               rem_d  = shamt;
               sign_d = din[N-1];
               if (shamt == '0) begin
                  result_d = din;
                  state_d  = ST_DONE;
               end else begin
                  state_d  = ST_SHIFT;
               end
            end
         end
         ST_SHIFT: begin
            acc_d = shifted;
            rem_d = rem_next;
            if (rem_next == '0) begin
               result_d = shifted;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // A squashed shift leaves every register as it was, apart from returning to IDLE.
      if (flush) begin
         state_d  = ST_IDLE;
         acc_d    = acc;
         rem_d    = rem;
         op_d     = op_q;
         sign_d   = sign;
         result_d = result;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc    <= '0;
         rem    <= '0;
         op_q   <= SH_SLL;
         sign   <= 1'b0;
         result <= '0;
         done   <= 1'b0;
         busy   <= 1'b0;
      end else begin
         acc    <= acc_d;
         rem    <= rem_d;
         op_q   <= op_d;
         sign   <= sign_d;
         result <= result_d;
         done   <= (state_d == ST_DONE);
         busy   <= (state_d != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit (N=32, STEP=8): vector table plus flush/reset/back-to-back sequences.
module tb_shift_unit;
   import shift_pkg::*;

   logic        clk = 1'b0;
   logic        rst, flush, start_valid, start_ready, done, busy;
   logic [1:0]  op;
   logic [31:0] din, result;
   logic [4:0]  shamt;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] din;
      logic [4:0]  shamt;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs [11];

   shift_unit #(.N(32), .STEP(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .op          (op),
      .din         (din),
      .shamt       (shamt),
      .result      (result),
      .done        (done),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", name, got, exp);
      end
   endtask

   // Issue one request at a negedge in IDLE and follow it until done (bounded).
   task automatic run_op(input vec_t v, input string name);
      int lat, nbusy;
      chk({name, " ready"}, 32'(start_ready), 32'd1);
      op = v.op; din = v.din; shamt = v.shamt; start_valid = 1'b1;
      lat = 0; nbusy = 0;
      do begin
         @(negedge clk);
         start_valid = 1'b0;
         lat++;
         if (busy) nbusy++;
      end while (!done && lat < 20);
      chk({name, " latency"}, 32'(lat), 32'(v.lat));
      chk({name, " result"}, result, v.exp);
      chk({name, " busy cycles"}, 32'(nbusy), 32'(v.lat));
      @(negedge clk);
      chk({name, " done pulse"}, 32'(done), 32'd0);
      chk({name, " idle busy"}, 32'(busy), 32'd0);
      chk({name, " ready again"}, 32'(start_ready), 32'd1);
   endtask

   initial begin
      int lat, ndone;
      vec_t v;

      vecs[0]  = '{SH_SLL,  32'h0000_0001, 5'd31, 32'h8000_0000, 5};
      vecs[1]  = '{SH_SRA,  32'h8000_00F0, 5'd4,  32'hF800_000F, 2};
      vecs[2]  = '{SH_SRL,  32'h8000_00F0, 5'd4,  32'h0800_000F, 2};
      vecs[3]  = '{SH_ROTL, 32'h8000_0001, 5'd1,  32'h0000_0003, 2};
      vecs[4]  = '{SH_ROTL, 32'h1234_5678, 5'd16, 32'h5678_1234, 3};
      vecs[5]  = '{SH_SRL,  32'h1234_5678, 5'd0,  32'h1234_5678, 1};
      vecs[6]  = '{SH_SRA,  32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 5};
      vecs[7]  = '{SH_ROTL, 32'h8000_0001, 5'd31, 32'hC000_0000, 5};
      vecs[8]  = '{SH_SRL,  32'hFFFF_FFFF, 5'd8,  32'h00FF_FFFF, 2};
      vecs[9]  = '{SH_SLL,  32'hFFFF_FFFF, 5'd9,  32'hFFFF_FE00, 3};
      vecs[10] = '{SH_SLL,  32'h5555_5555, 5'd1,  32'hAAAA_AAAA, 2};

      rst = 1'b1; flush = 1'b0; start_valid = 1'b1; op = SH_SLL; din = 32'h1; shamt = 5'd0;
      repeat (2) @(negedge clk);
      chk("reset result", result, 32'h0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset ready", 32'(start_ready), 32'd0);
      rst = 1'b0; start_valid = 1'b0;
      #1 chk("post-reset ready", 32'(start_ready), 32'd1);
      @(negedge clk);

      for (int i = 0; i < 11; i++) run_op(vecs[i], $sformatf("vec%0d", i));

      // Squash an SLL by 20 two cycles after accept.
      op = SH_SLL; din = 32'h1; shamt = 5'd20; start_valid = 1'b1;
      @(negedge clk); start_valid = 1'b0;
      @(negedge clk); flush = 1'b1;
      @(negedge clk);
      chk("flush done", 32'(done), 32'd0);
      chk("flush busy", 32'(busy), 32'd0);
      chk("flush result", result, 32'hAAAA_AAAA);
      flush = 1'b0;
      #1 chk("flush ready", 32'(start_ready), 32'd1);
      ndone = 0;
      repeat (6) begin @(negedge clk); if (done) ndone++; end
      chk("flush no done", 32'(ndone), 32'd0);

      // flush with a request in IDLE must not accept.
      flush = 1'b1; start_valid = 1'b1; op = SH_SRL; din = 32'h0000_0001; shamt = 5'd0;
      #1 chk("flush+valid ready", 32'(start_ready), 32'd0);
      @(negedge clk); flush = 1'b0; start_valid = 1'b0;
      chk("flush+valid done", 32'(done), 32'd0);
      chk("flush+valid busy", 32'(busy), 32'd0);
      chk("flush+valid result", result, 32'hAAAA_AAAA);

      // Reset mid-SHIFT with a request held.
      op = SH_SLL; din = 32'h1; shamt = 5'd31; start_valid = 1'b1;
      @(negedge clk);
      chk("pre-rst busy", 32'(busy), 32'd1);
      @(negedge clk); rst = 1'b1;
      #1 chk("rst ready", 32'(start_ready), 32'd0);
      @(negedge clk);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst result", result, 32'h0);
      @(negedge clk);
      chk("rst hold busy", 32'(busy), 32'd0);
      rst = 1'b0;

      // Back-to-back with start_valid held high; accepts only from IDLE, results in order.
      for (int i = 0; i < 3; i++) begin
         v = vecs[i + 2];
         op = v.op; din = v.din; shamt = v.shamt;
         #1 chk($sformatf("b2b%0d ready", i), 32'(start_ready), 32'd1);
         lat = 0;
         do begin @(negedge clk); lat++; end while (!done && lat < 20);
         chk($sformatf("b2b%0d latency", i), 32'(lat), 32'(v.lat));
         chk($sformatf("b2b%0d result", i), result, v.exp);
         @(negedge clk);
         chk($sformatf("b2b%0d idle", i), 32'(busy), 32'd0);
      end
      start_valid = 1'b0;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
